// File: rtl/add16_out_stage.sv
// 2-entry skid buffer registering adder results, plus accepted-beat statistics.
// Latency 1 cycle; in_ready is registered and drops only when both entries are full.
module add16_out_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sum,
  input  logic        in_carry,
  input  logic        in_parity,
  input  logic        in_overflow,
  input  logic        in_sign,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic [4:0]  out_flags,
  input  logic        clear_stats,
  output logic        sticky_ovf,
  output logic        sticky_carry,
  output logic [7:0]  ovf_count,
  output logic [15:0] txn_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [15:0] sum;
    logic [4:0]  flags;
  } beat_t;

  state_t state, state_nxt;
  beat_t  main_q, skid_q, in_beat;
  logic   in_fire, out_fire;
  logic   load_main, load_skid, move_skid;

  logic [15:0] txn_nxt;
  logic [7:0]  ovf_nxt;
  logic        sov_nxt, scar_nxt;

  assign in_beat   = '{sum: in_sum, flags: {in_zero, in_sign, in_overflow, in_parity, in_carry}};
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_sum   = main_q.sum;
  assign out_flags = main_q.flags;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the output side can move
        if (out_fire) begin
          move_skid = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
      if (load_main)      main_q <= in_beat;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_beat;
    end
  end

  // Clear takes effect first so a same-cycle beat still counts
  always_comb begin
    txn_nxt  = clear_stats ? 16'd0 : txn_count;
    ovf_nxt  = clear_stats ? 8'd0  : ovf_count;
    sov_nxt  = clear_stats ? 1'b0  : sticky_ovf;
    scar_nxt = clear_stats ? 1'b0  : sticky_carry;
    if (in_fire) begin
      txn_nxt  = txn_nxt + 16'd1;
      if (in_overflow && (ovf_nxt != 8'hFF)) ovf_nxt = ovf_nxt + 8'd1;
      sov_nxt  = sov_nxt | in_overflow;
      scar_nxt = scar_nxt | in_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count    <= '0;
      ovf_count    <= '0;
      sticky_ovf   <= 1'b0;
      sticky_carry <= 1'b0;
    end else begin
      txn_count    <= txn_nxt;
      ovf_count    <= ovf_nxt;
      sticky_ovf   <= sov_nxt;
      sticky_carry <= scar_nxt;
    end
  end

endmodule

// File: tb/tb_add16_out_stage.sv
// Bench for add16_out_stage: a 2-deep FIFO queue plus counters serve as the reference.
`timescale 1ns/1ps
module tb_add16_out_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_sum;
  logic        in_carry, in_parity, in_overflow, in_sign, in_zero;
  logic        out_valid, out_ready;
  logic [15:0] out_sum;
  logic [4:0]  out_flags;
  logic        clear_stats;
  logic        sticky_ovf, sticky_carry;
  logic [7:0]  ovf_count;
  logic [15:0] txn_count;

  int compared = 0;
  int mismatched = 0;

  // Reference: queue of pending {sum,flags} beats, capacity 2, plus statistics
  logic [20:0] exp_q[$];
  bit          m_rdy;
  int          m_txn, m_ovf;
  bit          m_sov, m_scar;

  always #5 clk = ~clk;

  add16_out_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_parity(in_parity),
    .in_overflow(in_overflow), .in_sign(in_sign), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_flags(out_flags),
    .clear_stats(clear_stats),
    .sticky_ovf(sticky_ovf), .sticky_carry(sticky_carry),
    .ovf_count(ovf_count), .txn_count(txn_count)
  );

  // Flags f = {zero,sign,overflow,parity,carry}. Called at negedge, returns at next negedge.
  task automatic drive_cycle(input bit v, input logic [15:0] s, input logic [4:0] f,
                             input bit ordy, input bit clr);
    bit infire, outfire;
    in_valid = v; in_sum = s; out_ready = ordy; clear_stats = clr;
    in_carry = f[0]; in_parity = f[1]; in_overflow = f[2]; in_sign = f[3]; in_zero = f[4];
    @(posedge clk);
    infire  = v && m_rdy;
    outfire = (exp_q.size() > 0) && ordy;
    if (clr) begin m_txn = 0; m_ovf = 0; m_sov = 0; m_scar = 0; end
    if (infire) begin
      m_txn = (m_txn + 1) % 65536;
      if (f[2] && m_ovf < 255) m_ovf++;
      m_sov  = m_sov | f[2];
      m_scar = m_scar | f[0];
    end
    if (outfire) void'(exp_q.pop_front());
    if (infire) exp_q.push_back({s, f});
    m_rdy = (exp_q.size() < 2);
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rdy = 0; m_txn = 0; m_ovf = 0; m_sov = 0; m_scar = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_sum = '0; out_ready = 0; clear_stats = 0;
    in_carry = 0; in_parity = 0; in_overflow = 0; in_sign = 0; in_zero = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compared++;
    if ({out_valid, in_ready, out_sum, out_flags} !== 23'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got vld=%b rdy=%b sum=%h flags=%b, want all 0",
               out_valid, in_ready, out_sum, out_flags);
    end
    compared++;
    if ({sticky_ovf, sticky_carry, ovf_count, txn_count} !== 26'd0) begin
      mismatched++;
      $display("FAIL reset_stats: got sov=%b scar=%b ovf=%h txn=%h, want all 0",
               sticky_ovf, sticky_carry, ovf_count, txn_count);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rdy_before_edge: got %b want 0", in_ready);
    end
    drive_cycle(0, 16'h0, 5'h0, 0, 0);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rdy_after_edge: got %b want 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    drive_cycle(0, 16'h0, 5'h0, 1, 1);
    for (int i = 1; i <= 3; i++) begin
      drive_cycle(1, 16'(i), 5'h0, 1, 0);
      compared++;
      if (out_valid !== 1'b1 || out_sum !== 16'(i) || in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_beat%0d: got vld=%b sum=%h rdy=%b, want vld=1 sum=%h rdy=1",
                 i, out_valid, out_sum, in_ready, 16'(i));
      end
    end
    compared++;
    if (txn_count !== 16'd3 || txn_count !== 16'(m_txn)) begin
      mismatched++;
      $display("FAIL b2b_txn: got %0d want 3", txn_count);
    end
    drive_cycle(0, 16'h0, 5'h0, 1, 0);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_drain: got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    drive_cycle(1, 16'h1111, 5'h0, 0, 0);
    drive_cycle(1, 16'h2222, 5'h0, 0, 0);
    compared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'h1111) begin
      mismatched++;
      $display("FAIL bp_full: got rdy=%b vld=%b sum=%h, want rdy=0 vld=1 sum=1111",
               in_ready, out_valid, out_sum);
    end
    drive_cycle(1, 16'h3333, 5'h0, 0, 0);
    compared++;
    if (out_sum !== 16'h1111 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_hold: got sum=%h rdy=%b, want sum=1111 rdy=0", out_sum, in_ready);
    end
    drive_cycle(0, 16'h0, 5'h0, 1, 0);
    compared++;
    if (out_valid !== 1'b1 || out_sum !== 16'h2222 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_release: got vld=%b sum=%h rdy=%b, want vld=1 sum=2222 rdy=1",
               out_valid, out_sum, in_ready);
    end
    drive_cycle(0, 16'h0, 5'h0, 1, 0);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_empty: got vld=%b want 0 (0x3333 must not be accepted)", out_valid);
    end
  endtask

  task automatic test_flag_mapping();
    drive_cycle(1, 16'h0000, 5'b10001, 1, 0);
    compared++;
    if (out_flags !== 5'b10001 || out_sum !== 16'h0000 || out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL flag_map: got flags=%b sum=%h vld=%b, want flags=10001 sum=0000 vld=1",
               out_flags, out_sum, out_valid);
    end
    drive_cycle(1, 16'hBEEF, 5'b01010, 1, 0);
    compared++;
    if (out_flags !== 5'b01010 || out_sum !== 16'hBEEF) begin
      mismatched++;
      $display("FAIL flag_map2: got flags=%b sum=%h, want flags=01010 sum=beef",
               out_flags, out_sum);
    end
    drive_cycle(0, 16'h0, 5'h0, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 16'($urandom), 5'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      compared++;
      if (in_ready !== m_rdy || out_valid !== (exp_q.size() > 0) ||
          (exp_q.size() > 0 && {out_sum, out_flags} !== exp_q[0])) begin
        mismatched++;
        $display("FAIL rand_data[%0d]: got rdy=%b vld=%b beat=%h, want rdy=%b vld=%b beat=%h",
                 i, in_ready, out_valid, {out_sum, out_flags}, m_rdy, exp_q.size() > 0,
                 (exp_q.size() > 0) ? exp_q[0] : 21'h0);
      end
      compared++;
      if (txn_count !== 16'(m_txn) || ovf_count !== 8'(m_ovf) ||
          sticky_ovf !== m_sov || sticky_carry !== m_scar) begin
        mismatched++;
        $display("FAIL rand_stats[%0d]: got txn=%h ovf=%h sov=%b scar=%b, want %h %h %b %b",
                 i, txn_count, ovf_count, sticky_ovf, sticky_carry,
                 16'(m_txn), 8'(m_ovf), m_sov, m_scar);
      end
    end
    repeat (3) drive_cycle(0, 16'h0, 5'h0, 1, 0);
  endtask

  task automatic test_overflow_stats();
    drive_cycle(0, 16'h0, 5'h0, 1, 1);
    for (int i = 0; i < 300; i++) drive_cycle(1, 16'($urandom), 5'b00100, 1, 0);
    compared++;
    if (ovf_count !== 8'hFF || sticky_ovf !== 1'b1 || sticky_carry !== 1'b0 ||
        ovf_count !== 8'(m_ovf)) begin
      mismatched++;
      $display("FAIL ovf_sat: got ovf=%h sov=%b scar=%b, want ovf=ff sov=1 scar=0",
               ovf_count, sticky_ovf, sticky_carry);
    end
    drive_cycle(1, 16'h1234, 5'b00001, 1, 0);
    compared++;
    if (sticky_carry !== 1'b1 || ovf_count !== 8'hFF) begin
      mismatched++;
      $display("FAIL sticky_carry: got scar=%b ovf=%h, want scar=1 ovf=ff",
               sticky_carry, ovf_count);
    end
  endtask

  task automatic test_wrap();
    drive_cycle(0, 16'h0, 5'h0, 1, 1);
    for (int i = 0; i < 65536; i++) drive_cycle(1, 16'(i), 5'h0, 1, 0);
    compared++;
    if (txn_count !== 16'h0000 || txn_count !== 16'(m_txn)) begin
      mismatched++;
      $display("FAIL txn_wrap: got %h want 0000", txn_count);
    end
    drive_cycle(1, 16'h7FFF, 5'b00100, 1, 1);
    compared++;
    if (txn_count !== 16'd1 || ovf_count !== 8'd1 || sticky_ovf !== 1'b1 ||
        out_sum !== 16'h7FFF) begin
      mismatched++;
      $display("FAIL clear_with_beat: got txn=%h ovf=%h sov=%b sum=%h, want 0001 01 1 7fff",
               txn_count, ovf_count, sticky_ovf, out_sum);
    end
    drive_cycle(0, 16'h0, 5'h0, 1, 0);
  endtask

  task automatic test_reset_full();
    drive_cycle(1, 16'hAAAA, 5'b00100, 0, 0);
    drive_cycle(1, 16'hBBBB, 5'b00001, 0, 0);
    compared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rf_setup: got rdy=%b vld=%b, want rdy=0 vld=1", in_ready, out_valid);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || txn_count !== 16'd0 ||
        ovf_count !== 8'd0 || sticky_ovf !== 1'b0 || sticky_carry !== 1'b0) begin
      mismatched++;
      $display("FAIL rf_async: got vld=%b rdy=%b txn=%h ovf=%h sov=%b scar=%b, want all 0",
               out_valid, in_ready, txn_count, ovf_count, sticky_ovf, sticky_carry);
    end
    #1 rst_n = 1'b1;
    drive_cycle(0, 16'h0, 5'h0, 1, 0);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rf_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    drive_cycle(0, 16'h0, 5'h0, 1, 0);
    compared++;
    if (out_valid !== 1'b0 || txn_count !== 16'd0) begin
      mismatched++;
      $display("FAIL rf_no_stale: got vld=%b txn=%h, want vld=0 txn=0000", out_valid, txn_count);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flag_mapping();
    test_random();
    test_overflow_stats();
    test_wrap();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
